dm_responder: RTL and testbench
===============================

# dm_responder

Data-memory responder at the far end of the MEM-stage memory interface. It accepts one load or store request at a time from the pipeline's MEM stage over a valid/ready handshake and returns read data or a completion after a configurable fixed latency. Stores use byte enables. Misaligned or out-of-range accesses are flagged instead of executed. The MEM stage stalls on `req_ready` low, so this block replaces a zero-latency, combinational data memory with a multi-cycle responder.

## Interface
- `DEPTH_LOG2`, default 10: log2 of memory depth in 32-bit words (1024 words, byte addresses 0x0000–0x0FFF).
- `LATENCY`, default 2: cycles from the acceptance edge to the response cycle. Legal range is 1–15.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder idle and able to accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_be`  in  4  byte enables for stores; bit i covers `wdata[8i+7:8i]`. Ignored for loads.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, already lane-aligned.
- `req_pc`  in  32  PC of the issuing instruction; used for logging only.
- `resp_valid`  out  1  one-cycle response strobe.
- `resp_rdata`  out  32  load data. It is 0 for stores and for errors.
- `resp_err`  out  1  access rejected; valid while `resp_valid` is high.

## Operation
- The FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid & req_ready`, latch we/be/addr/wdata/pc.
  - Load the counter with LATENCY-1.
  - Go to RESP if LATENCY = 1, otherwise go to WAIT.
- WAIT:
  - `req_ready` = 0.
  - The counter decrements each cycle.
  - Go to RESP when the counter reaches 1.
- RESP:
  - `req_ready` = 0 and `resp_valid` = 1 for exactly one cycle.
  - Always return to IDLE on the next edge.
- Error check, evaluated on the latched address:
  - `addr[1:0]` ≠ 0 is an error.
  - Any nonzero bit in `addr[31:DEPTH_LOG2+2]` is an error.
  - On error: `resp_err` = 1, `resp_rdata` = 0, no memory write.
- Load: `resp_rdata` is the word at `addr[DEPTH_LOG2+1:2]`, read during RESP.
- Store:
  - On the edge leaving RESP, each enabled byte lane is written.
  - Disabled lanes keep their old value.
  - `be` = 0000 is a legal no-op store: no error and no write.
- A load issued immediately after a store to the same word returns the merged (new) word.
- Only one transaction is outstanding at a time; there is no pipelining and no queue.
- Reset:
  - Outputs go to `req_ready` = 1 (state IDLE), `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0.
  - All memory words are cleared to 0.
  - An in-flight transaction is discarded and its write is never committed.

## Timing
- The acceptance edge is E0.
- `resp_valid` is high in the cycle between edges E0+LATENCY-1 and E0+LATENCY.
- A store commits at edge E0+LATENCY.
- `req_ready` rises again after edge E0+LATENCY.
- Maximum throughput is one request per LATENCY+1 cycles.
- `req_valid` asserted while `req_ready` = 0 is ignored. The requester must hold the request until it is accepted.
- `resp_rdata` and `resp_err` are registered or derived from latched state only. They have no combinational path from the `req_*` inputs.
- Asserting `reset` during RESP deasserts `resp_valid` immediately (asynchronous).

## Configuration
- `DM_WRITE_LOG_EN` defined: at every committed store, print `$display("@%h: *%h <= %h", pc, {addr[31:2],2'b00}, merged_word)` using the latched PC.
  - Nothing is printed for errors or for `be` = 0000.
- `DM_WRITE_LOG_EN` undefined: no simulation output. Logic is otherwise identical.

## Structure
- The shared package holds:
  - the FSM state typedef (IDLE/WAIT/RESP);
  - the byte-enable width constant (4);
  - the `LATENCY` legal-range bounds.
- One sub-module, `dm_bank`:
  - word array with asynchronous clear;
  - combinational read port;
  - byte-enabled synchronous write port.
- The FSM, counter, request latch, error check and logging live in `dm_responder`.

## Test plan
- Reset, then load from 0x0000 → `resp_valid` in the 2nd cycle after acceptance (LATENCY=2), with `resp_rdata` = 0x00000000 and `resp_err` = 0.
- Store 0x12345678, be=1111, to 0x0010; then store 0xAABBCCDD, be=0101, to 0x0010; then load from 0x0010 → 0x12BB56DD.
- Misaligned store to 0x0013 → `resp_err` = 1 and `resp_rdata` = 0; a subsequent load from 0x0010 returns the unchanged word.
- Load from 0x1000 with DEPTH_LOG2=10 → `resp_err` = 1 and `resp_rdata` = 0.
- Hold `req_valid` continuously for 3 requests → accepted at cycles 0, 3 and 6 (LATENCY=2); `req_ready` = 0 in between.
- Store of 0xFFFFFFFF to 0x0020, asserting `reset` during WAIT; then a load from 0x0020 → 0x00000000, and `resp_valid` never pulsed for the aborted store.

Source files
------------

// File: rtl/dm_responder_pkg.sv
// Shared types and constants for the dm_responder data-memory responder.
package dm_responder_pkg;

  localparam int BE_W    = 4;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_e;

  // Lane-wise merge: enabled bytes come from new_w, the rest from old_w.
  function automatic logic [31:0] merge_word(input logic [31:0]     old_w,
                                             input logic [31:0]     new_w,
                                             input logic [BE_W-1:0] be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// MEM-stage request/response bundle between the pipeline (master) and dm_responder (slave).
interface dm_responder_if;
  import dm_responder_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [BE_W-1:0] req_be;
  logic [31:0]     req_addr;
  logic [31:0]     req_wdata;
  logic [31:0]     req_pc;
  logic            resp_valid;
  logic [31:0]     resp_rdata;
  logic            resp_err;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata, req_pc,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata, req_pc,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dm_responder_bank.sv
// dm_bank: word store split into byte lanes, asynchronous clear, combinational read,
// byte-enabled synchronous write on a shared word address.
module dm_bank
  import dm_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic                  we_i,
  input  logic [BE_W-1:0]       be_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // One independent byte array per lane keeps each lane's write logic self-contained.
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    logic [7:0] lane_q [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < DEPTH; i++) lane_q[i] <= 8'h00;
      end else if (we_i && be_i[gi]) begin
        lane_q[addr_i] <= wdata_i[8*gi +: 8];
      end
    end

    assign rdata_o[8*gi +: 8] = lane_q[addr_i];
  end

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: one request at a time, fixed LATENCY, byte-enabled stores.
// Define DM_WRITE_LOG_EN to print every committed store.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic         clk,
  input  logic         reset,
  dm_responder_if.slave bus
);

  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
    $error("dm_responder: LATENCY must be within 1..15");
  end

  dm_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic [BE_W-1:0]  be_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      pc_q;
  logic             req_ready_q;
  logic             resp_valid_q;

  logic             err_w;
  logic             wr_en;
  logic [31:0]      rd_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      pc_q         <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            we_q        <= bus.req_we;
            be_q        <= bus.req_be;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            pc_q        <= bus.req_pc;
            cnt_q       <= CNT_W'(LATENCY - 1);
            req_ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q <= 1) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
          end
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
        default: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // Checked against the latched address only, so responses never see the live request bus.
  assign err_w = (addr_q[1:0] != 2'b00) || (|addr_q[31:DEPTH_LOG2+2]);

  // The write lands on the edge that leaves RESP; a reset before then drops it.
  assign wr_en = (state_q == RESP) && we_q && !err_w && (be_q != '0);

  dm_bank #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .addr_i  (addr_q[DEPTH_LOG2+1:2]),
    .we_i    (wr_en),
    .be_i    (be_q),
    .wdata_i (wdata_q),
    .rdata_o (rd_word)
  );

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_valid_q && err_w;
  assign bus.resp_rdata = (resp_valid_q && !we_q && !err_w) ? rd_word : 32'h0;

`ifdef DM_WRITE_LOG_EN
  always @(posedge clk) begin
    if (reset && wr_en) begin
      $display("@%h: *%h <= %h", pc_q, {addr_q[31:2], 2'b00},
               merge_word(rd_word, wdata_q, be_q));
    end
  end
`else
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder (DEPTH_LOG2=10, LATENCY=2).
module tb_dm_responder;
  import dm_responder_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  dm_responder_if bus_if ();

  dm_responder #(
    .DEPTH_LOG2(10),
    .LATENCY   (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one request, wait for acceptance, then find the response cycle (1 = first cycle after E0).
  task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic err, output int lat);
    int n;
    lat   = -1;
    rdata = 32'hDEAD_BEEF;
    err   = 1'bx;
    @(negedge clk);
    bus_if.req_we    = we;
    bus_if.req_be    = be;
    bus_if.req_addr  = addr;
    bus_if.req_wdata = wdata;
    bus_if.req_pc    = 32'h0000_1000 + addr;
    bus_if.req_valid = 1'b1;
    n = 0;
    while (!bus_if.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus_if.resp_valid) begin
        lat   = k;
        rdata = bus_if.resp_rdata;
        err   = bus_if.resp_err;
        break;
      end
    end
    $display("txn we=%0b be=%b addr=%h wdata=%h -> lat=%0d rdata=%h err=%0b",
             we, be, addr, wdata, lat, rdata, err);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (bus_if.req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b want=1", bus_if.req_ready);
    end
    total++;
    if (bus_if.resp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b want=0", bus_if.resp_valid);
    end
    total++;
    if (bus_if.resp_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_rdata got=%h want=00000000", bus_if.resp_rdata);
    end
    total++;
    if (bus_if.resp_err !== 1'b0) begin
      bad++; $display("FAIL reset_err got=%b want=0", bus_if.resp_err);
    end
  endtask

  task automatic test_load_zero();
    logic [31:0] rd; logic er; int lat;
    issue(1'b0, 4'h0, 32'h0000_0000, 32'h0, rd, er, lat);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL load0_latency got=%0d want=2", lat); end
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL load0_rdata got=%h want=00000000", rd); end
    total++;
    if (er !== 1'b0) begin bad++; $display("FAIL load0_err got=%b want=0", er); end
  endtask

  task automatic test_store_merge();
    logic [31:0] rd; logic er; int lat;
    issue(1'b1, 4'b1111, 32'h0000_0010, 32'h1234_5678, rd, er, lat);
    total++;
    if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin
      bad++; $display("FAIL store_full got lat=%0d err=%b rdata=%h want lat=2 err=0 rdata=0", lat, er, rd);
    end
    issue(1'b1, 4'b0101, 32'h0000_0010, 32'hAABB_CCDD, rd, er, lat);
    total++;
    if (lat !== 2 || er !== 1'b0) begin
      bad++; $display("FAIL store_partial got lat=%0d err=%b want lat=2 err=0", lat, er);
    end
    issue(1'b0, 4'h0, 32'h0000_0010, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h12BB_56DD) begin bad++; $display("FAIL merge_rdata got=%h want=12bb56dd", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic er; int lat;
    issue(1'b1, 4'b1111, 32'h0000_0013, 32'hFFFF_FFFF, rd, er, lat);
    total++;
    if (er !== 1'b1) begin bad++; $display("FAIL misalign_err got=%b want=1", er); end
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL misalign_rdata got=%h want=00000000", rd); end
    issue(1'b0, 4'h0, 32'h0000_0010, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h12BB_56DD) begin bad++; $display("FAIL misalign_nowrite got=%h want=12bb56dd", rd); end
  endtask

  task automatic test_range();
    logic [31:0] rd; logic er; int lat;
    issue(1'b0, 4'h0, 32'h0000_1000, 32'h0, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL range_high got err=%b rdata=%h want err=1 rdata=0", er, rd);
    end
    issue(1'b1, 4'b1100, 32'h0000_0FFC, 32'hCAFE_0000, rd, er, lat);
    total++;
    if (er !== 1'b0) begin bad++; $display("FAIL range_top_store got err=%b want=0", er); end
    issue(1'b0, 4'h0, 32'h0000_0FFC, 32'h0, rd, er, lat);
    total++;
    if (er !== 1'b0 || rd !== 32'hCAFE_0000) begin
      bad++; $display("FAIL range_top_load got err=%b rdata=%h want err=0 rdata=cafe0000", er, rd);
    end
    issue(1'b0, 4'h0, 32'h8000_0010, 32'h0, rd, er, lat);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      bad++; $display("FAIL range_msb got err=%b rdata=%h want err=1 rdata=0", er, rd);
    end
  endtask

  task automatic test_be_zero();
    logic [31:0] rd; logic er; int lat;
    issue(1'b1, 4'b0000, 32'h0000_0010, 32'hFFFF_FFFF, rd, er, lat);
    total++;
    if (er !== 1'b0 || lat !== 2) begin
      bad++; $display("FAIL be0_store got err=%b lat=%0d want err=0 lat=2", er, lat);
    end
    issue(1'b0, 4'h0, 32'h0000_0010, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h12BB_56DD) begin bad++; $display("FAIL be0_nowrite got=%h want=12bb56dd", rd); end
  endtask

  task automatic test_back_to_back();
    int acc [3];
    int nacc;
    int low;
    nacc = 0;
    low  = 0;
    @(negedge clk);
    bus_if.req_we    = 1'b0;
    bus_if.req_be    = 4'h0;
    bus_if.req_addr  = 32'h0000_0010;
    bus_if.req_wdata = 32'h0;
    bus_if.req_valid = 1'b1;
    for (int c = 0; c < 20 && nacc < 3; c++) begin
      if (c != 0) @(negedge clk);
      if (bus_if.req_ready) begin
        acc[nacc] = c;
        nacc++;
      end else begin
        low++;
      end
    end
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    $display("txn back_to_back accepted=%0d at %0d,%0d,%0d ready_low=%0d",
             nacc, acc[0], acc[1], acc[2], low);
    total++;
    if (nacc !== 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", nacc); end
    total++;
    if (acc[1] !== 3) begin bad++; $display("FAIL b2b_second got=%0d want=3", acc[1]); end
    total++;
    if (acc[2] !== 6) begin bad++; $display("FAIL b2b_third got=%0d want=6", acc[2]); end
    total++;
    if (low !== 4) begin bad++; $display("FAIL b2b_ready_low got=%0d want=4", low); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int lat;
    int pulses;
    pulses = 0;
    @(negedge clk);
    bus_if.req_we    = 1'b1;
    bus_if.req_be    = 4'b1111;
    bus_if.req_addr  = 32'h0000_0020;
    bus_if.req_wdata = 32'hFFFF_FFFF;
    bus_if.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus_if.req_ready !== 1'b0) begin
      bad++; $display("FAIL abort_in_wait got ready=%b want=0", bus_if.req_ready);
    end
    reset = 1'b0;
    #1;
    if (bus_if.resp_valid) pulses++;
    total++;
    if (bus_if.req_ready !== 1'b1) begin
      bad++; $display("FAIL abort_ready_in_reset got=%b want=1", bus_if.req_ready);
    end
    repeat (2) begin
      @(negedge clk);
      if (bus_if.resp_valid) pulses++;
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus_if.resp_valid) pulses++;
    end
    $display("txn reset_abort store addr=00000020 resp_pulses=%0d", pulses);
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL abort_pulses got=%0d want=0", pulses); end
    issue(1'b0, 4'h0, 32'h0000_0020, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h0 || lat !== 2) begin
      bad++; $display("FAIL abort_load got rdata=%h lat=%0d want rdata=0 lat=2", rd, lat);
    end
    issue(1'b0, 4'h0, 32'h0000_0010, 32'h0, rd, er, lat);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL abort_cleared got=%h want=00000000", rd); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus_if.req_valid = 1'b0;
    bus_if.req_we    = 1'b0;
    bus_if.req_be    = 4'h0;
    bus_if.req_addr  = 32'h0;
    bus_if.req_wdata = 32'h0;
    bus_if.req_pc    = 32'h0;
    test_reset();
    test_load_zero();
    test_store_merge();
    test_misaligned();
    test_range();
    test_be_zero();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
